sqrt_check: RTL and testbench
=============================

// Module: sqrt_check
// PURPOSE
//   Multi-cycle integer squarer and floor-sqrt checker; the inverse companion of the sqrt unit.
//   Takes a candidate root r and a radicand a, and computes r*r by iterative shift-add.
//   Flags whether r == floor(sqrt(a)). Used in self-check paths downstream of the sqrt unit.
//   Uses the same start/busy/valid handshake as the sqrt unit.
// PARAMETERS
//   WIDTH  32  width of a_i and r_i; square_o is 2*WIDTH
//   BPC    1   multiplier bits consumed per cycle; legal 1, 2, 4; WIDTH % BPC == 0 (elaboration assert)
// PORTS
//   clk_i     in   1        clock, rising edge
//   rst_ni    in   1        asynchronous, active-low reset
//   start_i   in   1        request; sampled only in IDLE
//   a_i       in   WIDTH    radicand; captured on accepted start
//   r_i       in   WIDTH    candidate root; captured on accepted start
//   valid_o   out  1        result valid; held until the next accepted start
//   busy_o    out  1        high whenever state != IDLE
//   square_o  out  2*WIDTH  r*r
//   ok_o      out  1        1 iff r*r <= a < (r+1)*(r+1)
// BEHAVIOUR
//   Reset (async, rst_ni=0):
//     state=IDLE; valid_o=0, busy_o=0, square_o=0, ok_o=0; all internal registers cleared.
//     Reset mid-operation aborts the operation; no valid pulse is produced.
//   Registers:
//     a_reg[W], mcand[2W] (r, shifted left), mplier[W] (r, shifted right), acc[2W], ok_reg.
//   States:
//     IDLE:  start_i=1 -> a_reg=a_i, mcand=r_i, mplier=r_i, acc=0, valid_o<=0, go MUL.
//            start_i=0 -> hold all.
//     MUL:   mplier!=0 -> acc += mplier[BPC-1:0]*mcand; mcand <<= BPC; mplier >>= BPC; stay.
//            mplier==0 -> go CHECK (no arithmetic this cycle).
//     CHECK: ok_reg = (acc <= a_reg) && (a_reg < acc + 2*mcand0 + 1); valid_o<=1; go IDLE.
//            mcand0 is r held in a separate WIDTH-bit r_reg captured at start.
//   Arithmetic:
//     acc never overflows 2W bits (max (2^W-1)^2).
//     The CHECK upper bound is evaluated in 2W+1 bits, so r=2^W-1 gives a correct bound of 2^2W.
//     The unsigned compare zero-extends a_reg.
//   Latency: K = ceil(bitlen(r)/BPC), bitlen(0)=0.
//     valid_o rises on the (K+2)th rising edge after the accepted-start edge.
//     busy_o is high for exactly K+2 cycles.
//     Early termination is data dependent; worst case W/BPC+2.
//   Outputs:
//     square_o = acc and ok_o = ok_reg, driven continuously.
//     Both are stable and meaningful only while valid_o=1.
//     square_o is the running partial product while busy.
//   Handshake:
//     start_i is ignored while busy_o=1; no queueing.
//     start_i held high in IDLE in the same cycle valid_o rises: the new op is accepted
//       on the next edge, and valid_o drops on that edge.
//     Back-to-back operations therefore have one IDLE cycle between them.
//     Changes to a_i/r_i after the accepted start have no effect.
//   Illegal state encoding -> IDLE.
// STRUCTURE
//   sqrt_pkg (shared with the sqrt unit):
//     typedef enum logic [1:0] {IDLE, MUL, CHECK} sqchk_state_t;
//     localparam legal-BPC check function.
//   One sub-module, sqrt_check_step (combinational):
//     mcand, digit[BPC] -> partial product [2W], for reuse across BPC variants.
//   FSM and datapath registers stay in sqrt_check.
// TESTING
//   1. r=0, a=0, BPC=1 -> square_o=0, ok_o=1; valid_o 2 edges after start; busy_o high 2 cycles.
//   2. r=3, a=15 -> square_o=9, ok_o=1. Then r=3, a=16 -> ok_o=0.
//      Also r=5, BPC=1 -> valid_o 5 edges after start.
//   3. W=32: r=0xFFFF, a=0xFFFFFFFF -> square_o=0xFFFE0001, ok_o=1.
//      r=0x10000, same a -> square_o=0x1_0000_0000, ok_o=0.
//   4. r=0xFFFFFFFF, a=0xFFFFFFFF -> square_o=0xFFFFFFFE_00000001, ok_o=0; no 2W+1 overflow.
//      Repeat with BPC=2 and BPC=4: same values, latency 18 and 10 respectively.
//   5. start_i pulsed with new a_i/r_i while busy -> ignored; first result unchanged.
//      start_i held high -> ops back to back with one IDLE cycle; valid_o drops on each accept.
//   6. rst_ni low mid-MUL -> all outputs 0 immediately (asynchronous).
//      After release, a fresh start completes with the correct result.
//   Scoreboard: random r and a (all BPC) against a golden model r*r and isqrt(a)==r.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt unit family: FSM state encoding and the
// legal-parameter check used at elaboration.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MUL   = 2'b01,
    CHECK = 2'b10
  } sqchk_state_t;

  // Digits per cycle must be a supported radix and must tile the operand.
  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/sqrt_check_step.sv
// One shift-add step: multiplies the shifted multiplicand by a BPC-bit digit
// of the multiplier, producing a 2*WIDTH partial product.
module sqrt_check_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [BPC-1:0]     digit,
  output logic [2*WIDTH-1:0] pp
);

  // Sum of mcand shifted by each set digit bit; upper bits shifted out are
  // always zero because the digit only has bits where r does.
  always_comb begin
    pp = {(2*WIDTH){1'b0}};
    for (int i = 0; i < BPC; i++) begin
      if (digit[i]) begin
        pp = pp + (mcand << i);
      end else begin
        pp = pp;
      end
    end
  end

endmodule

// File: rtl/sqrt_check.sv
// Multi-cycle squarer that verifies a candidate root: computes r*r by
// iterative shift-add and flags whether r == floor(sqrt(a)).
module sqrt_check
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   r_i,
  output logic               valid_o,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] square_o,
  output logic               ok_o
);

  localparam int W2 = 2 * WIDTH;

  if (!bpc_legal(WIDTH, BPC)) begin : g_bad_bpc
    $error("sqrt_check: BPC must be 1, 2 or 4 and divide WIDTH");
  end

  sqchk_state_t   state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] r_r, r_s;
  logic [W2-1:0]    mcand_r, mcand_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
  logic [W2-1:0]    acc_r, acc_s;
  logic             ok_r, ok_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;

  logic [W2-1:0]    pp_s;
  logic [W2:0]      acc_ext_s;
  logic [W2:0]      a_ext_s;
  logic [W2:0]      upper_s;

  sqrt_check_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .mcand (mcand_r),
    .digit (mplier_r[BPC-1:0]),
    .pp    (pp_s)
  );

  // Upper bound (r+1)^2 = acc + 2r + 1 needs one extra bit for r = 2^W-1.
  assign acc_ext_s = {1'b0, acc_r};
  assign a_ext_s   = {{(WIDTH+1){1'b0}}, a_r};
  assign upper_s   = acc_ext_s + {{WIDTH{1'b0}}, r_r, 1'b0} + {{W2{1'b0}}, 1'b1};

  // Next-state and datapath update.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    r_s      = r_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    ok_s     = ok_r;
    valid_s  = valid_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          a_s      = a_i;
          r_s      = r_i;
          mcand_s  = {{WIDTH{1'b0}}, r_i};
          mplier_s = r_i;
          acc_s    = {W2{1'b0}};
          valid_s  = 1'b0;
          state_s  = MUL;
        end else begin
          state_s  = IDLE;
        end
      end
      MUL: begin
        if (mplier_r != {WIDTH{1'b0}}) begin
          acc_s    = acc_r + pp_s;
          mcand_s  = mcand_r << BPC;
          mplier_s = mplier_r >> BPC;
          state_s  = MUL;
        end else begin
          state_s  = CHECK;
        end
      end
      CHECK: begin
        ok_s    = (acc_ext_s <= a_ext_s) && (a_ext_s < upper_s);
        valid_s = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      r_r      <= {WIDTH{1'b0}};
      mcand_r  <= {W2{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {W2{1'b0}};
      ok_r     <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      r_r      <= r_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      ok_r     <= ok_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
    end
  end

  assign valid_o  = valid_r;
  assign busy_o   = busy_r;
  assign square_o = acc_r;
  assign ok_o     = ok_r;

endmodule

// File: tb/tb_sqrt_check.sv
// Self-checking bench for sqrt_check: directed vector table, corner-case
// sequences and a random scoreboard across BPC = 1, 2, 4.
module tb_sqrt_check;

  logic        clk;
  logic        rst_n;
  logic        start [3];
  logic [31:0] a;
  logic [31:0] r;
  logic        valid [3];
  logic        busy  [3];
  logic [63:0] sq    [3];
  logic        ok    [3];

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [63:0] sq;
    logic        ok;
    int          lat;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] r;
    logic [63:0] sq;
    logic        ok;
    int          lat;
  } vec_t;

  exp_t sb_q [$];
  vec_t tbl [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sqrt_check #(
      .WIDTH (32),
      .BPC   (1 << g)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start[g]),
      .a_i      (a),
      .r_i      (r),
      .valid_o  (valid[g]),
      .busy_o   (busy[g]),
      .square_o (sq[g]),
      .ok_o     (ok[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic int bitlen(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [63:0] res;
    logic [63:0] t;
    res = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = res | (64'd1 << b);
      if (t * t <= {32'd0, v}) res = t;
    end
    return res[31:0];
  endfunction

  function automatic exp_t model(input int d, input logic [31:0] av, input logic [31:0] rv);
    exp_t e;
    int bpc;
    bpc   = 1 << d;
    e.sq  = {32'd0, rv} * {32'd0, rv};
    e.ok  = (isqrt(av) == rv);
    e.lat = (bitlen(rv) + bpc - 1) / bpc + 2;
    return e;
  endfunction

  // One operation: push expectation, drive start, count edges to valid, pop and compare.
  task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] rv, input exp_t e);
    exp_t got;
    int   n;
    sb_q.push_back(e);
    @(negedge clk);
    a = av; r = rv; start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk("valid_drop_on_accept", {63'd0, valid[d]}, 64'd0);
    chk("busy_after_accept", {63'd0, busy[d]}, 64'd1);
    n = 0;
    while (!valid[d] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    got = sb_q.pop_front();
    if (!valid[d]) chk("valid_timeout", 64'd0, 64'd1);
    chk("latency", 64'(n), 64'(got.lat));
    chk("busy_low_at_valid", {63'd0, busy[d]}, 64'd0);
    chk("square", sq[d], got.sq);
    chk("ok", {63'd0, ok[d]}, {63'd0, got.ok});
  endtask

  task automatic wait_valid0(input int bound);
    int n;
    n = 0;
    while (!valid[0] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!valid[0]) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra;
    logic [31:0] rr;
    int d;

    tbl[0] = '{0, 32'd0,          32'd0,          64'd0,                 1'b1, 2};
    tbl[1] = '{0, 32'd15,         32'd3,          64'd9,                 1'b1, 4};
    tbl[2] = '{0, 32'd16,         32'd3,          64'd9,                 1'b0, 4};
    tbl[3] = '{0, 32'd25,         32'd5,          64'd25,                1'b1, 5};
    tbl[4] = '{0, 32'hFFFFFFFF,   32'h0000FFFF,   64'hFFFE0001,          1'b1, 18};
    tbl[5] = '{0, 32'hFFFFFFFF,   32'h00010000,   64'h1_0000_0000,       1'b0, 19};
    tbl[6] = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0, 34};
    tbl[7] = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0, 18};
    tbl[8] = '{2, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0, 10};
    tbl[9] = '{2, 32'd48,         32'd7,          64'd49,                1'b0, 3};

    rst_n = 1'b0;
    a = 32'd0; r = 32'd0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", {63'd0, valid[i]}, 64'd0);
      chk("reset_busy", {63'd0, busy[i]}, 64'd0);
      chk("reset_square", sq[i], 64'd0);
      chk("reset_ok", {63'd0, ok[i]}, 64'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.sq = tbl[i].sq; e.ok = tbl[i].ok; e.lat = tbl[i].lat;
      do_op(tbl[i].d, tbl[i].a, tbl[i].r, e);
    end

    // start pulsed while busy is ignored; no queued operation afterwards
    @(negedge clk);
    a = 32'd100; r = 32'd10; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; a = 32'd7; r = 32'd2;
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_valid0(50);
    chk("ignore_square", sq[0], 64'd100);
    chk("ignore_ok", {63'd0, ok[0]}, 64'd1);
    repeat (3) @(negedge clk);
    chk("ignore_no_queue", {63'd0, busy[0]}, 64'd0);
    chk("ignore_valid_held", {63'd0, valid[0]}, 64'd1);

    // start held high: back-to-back with one IDLE cycle
    a = 32'd15; r = 32'd3; start[0] = 1'b1;
    @(negedge clk);
    wait_valid0(50);
    chk("b2b_first_square", sq[0], 64'd9);
    chk("b2b_first_ok", {63'd0, ok[0]}, 64'd1);
    a = 32'd16;
    @(negedge clk);
    chk("b2b_valid_drop", {63'd0, valid[0]}, 64'd0);
    chk("b2b_busy", {63'd0, busy[0]}, 64'd1);
    wait_valid0(50);
    start[0] = 1'b0;
    chk("b2b_second_square", sq[0], 64'd9);
    chk("b2b_second_ok", {63'd0, ok[0]}, 64'd0);
    @(negedge clk);
    chk("b2b_stop", {63'd0, busy[0]}, 64'd0);

    // asynchronous reset mid-MUL
    a = 32'd0; r = 32'hFFFFFFFF; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy[0]}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {63'd0, valid[0]}, 64'd0);
    chk("areset_busy", {63'd0, busy[0]}, 64'd0);
    chk("areset_square", sq[0], 64'd0);
    chk("areset_ok", {63'd0, ok[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 32'd200, 32'd14, model(0, 32'd200, 32'd14));

    // random scoreboard
    for (int i = 0; i < 60; i++) begin
      d = i % 3;
      if (i % 4 == 3) begin
        rr = $urandom;
        ra = $urandom;
      end else begin
        rr = $urandom_range(0, 32'hFFFF);
        ra = rr * rr + $urandom_range(0, 2 * rr + 1);
      end
      do_op(d, ra, rr, model(d, ra, rr));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
